lc3x_multicycle_sequencer: RTL

Execute-stage sequencer for LC-3x instructions that need more than one cycle.
- Multicycle ALU ops: op_ops MULT and DIV.
- Memory ops: single-phase loads/stores and TRAP, plus two-phase indirect LDI/STI.
- Latches the issued op, runs a small FSM and drives the pipeline stall, mult/div unit start and memory read/write strobes. Signals completion to the rest of the pipeline.
- Parametrised successor of the single-cycle decode: latencies and counter width are generics, and it adds sequencing, abort and indirect phasing.

---
 rtl/lc3x_multicycle_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lc3x_multicycle_sequencer.sv
// Execute-stage sequencer for multicycle LC-3x ops (MULT/DIV, loads/stores/TRAP, LDI/STI).
// Latency: MULT_CYCLES/DIV_CYCLES for mult/div, memory ops wait on mem_resp; stall holds upstream until done.
// Backpressure: stall asserts combinationally on issue and stays high while busy, dropping in the done cycle.
module lc3x_multicycle_sequencer #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 17,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [3:0]       opcode,
    input  logic [2:0]       ir_5_3,
    input  logic             mem_resp,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             md_start,
    output logic             md_select,
    output logic             mem_read,
    output logic             mem_write,
    output logic             indirect_phase,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MULDIV = 2'd1;
    localparam logic [1:0] S_MEM1   = 2'd2;
    localparam logic [1:0] S_MEM2   = 2'd3;

    localparam logic [3:0] OP_OPS  = 4'b1000;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_TRAP = 4'b1111;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int RW   = $clog2(MAXC + 1);
    localparam logic [RW-1:0] MULT_LAST = RW'(MULT_CYCLES - 1);
    localparam logic [RW-1:0] DIV_LAST  = RW'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state, next_state;
    logic [3:0]       op_q;
    logic             md_sel_q;
    logic             first_q;
    logic             abort_q;
    logic [RW-1:0]    remaining;

    logic is_alu, is_mem, issue;
    logic q_write1, q_indirect, q_sti, abort_now;

    assign is_alu = (opcode == OP_OPS) && (ir_5_3[2:1] == 2'b00);
    assign is_mem = (opcode == OP_LDR) || (opcode == OP_LDB) || (opcode == OP_TRAP) ||
                    (opcode == OP_STR) || (opcode == OP_STB) ||
                    (opcode == OP_LDI) || (opcode == OP_STI);
    assign issue  = (state == S_IDLE) && issue_valid && !flush && !reset && (is_alu || is_mem);

    assign q_write1   = (op_q == OP_STR) || (op_q == OP_STB);
    assign q_indirect = (op_q == OP_LDI) || (op_q == OP_STI);
    assign q_sti      = (op_q == OP_STI);
    // A flush arriving together with mem_resp aborts just like an earlier one.
    assign abort_now  = abort_q || flush;

    always_comb begin
        next_state     = state;
        done           = 1'b0;
        md_start       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        indirect_phase = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue)
                    next_state = is_alu ? S_MULDIV : S_MEM1;
            end
            S_MULDIV: begin
                md_start = first_q;
                if (flush) begin
                    next_state = S_IDLE;
                end else if (remaining == '0) begin
                    done       = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_MEM1: begin
                mem_write = q_write1;
                mem_read  = !q_write1;
                if (mem_resp) begin
                    if (abort_now) begin
                        next_state = S_IDLE;
                    end else if (q_indirect) begin
                        next_state = S_MEM2;
                    end else begin
                        done       = 1'b1;
                        next_state = S_IDLE;
                    end
                end
            end
            S_MEM2: begin
                indirect_phase = 1'b1;
                mem_write      = q_sti;
                mem_read       = !q_sti;
                if (mem_resp) begin
                    done       = !abort_now;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign stall     = issue || (busy && !done);
    assign md_select = (state == S_MULDIV) && md_sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= '0;
            md_sel_q    <= 1'b0;
            first_q     <= 1'b0;
            abort_q     <= 1'b0;
            remaining   <= '0;
            cycle_count <= '0;
        end else begin
            state <= next_state;
            if (issue) begin
                op_q        <= opcode;
                md_sel_q    <= ir_5_3[0];
                remaining   <= ir_5_3[0] ? DIV_LAST : MULT_LAST;
                first_q     <= 1'b1;
                abort_q     <= 1'b0;
                cycle_count <= '0;
            end else if (busy) begin
                first_q <= 1'b0;
                if (remaining != '0)
                    remaining <= remaining - RW'(1);
                if (flush && state != S_MULDIV)
                    abort_q <= 1'b1;
                if (next_state == S_IDLE)
                    abort_q <= 1'b0;
                // Count stops on the exit cycle so IDLE shows the op's final count.
                if (next_state != S_IDLE && cycle_count != CNT_MAX)
                    cycle_count <= cycle_count + 1'b1;
            end
        end
    end

endmodule
